// File: rtl/timer_unit_ctrl.sv
// timer_unit_ctrl: control sequencer for one timer channel.
// Holds the channel configuration register. Arms, runs and stops the
// prescaler and main counters. Turns main-counter compare hits into a
// registered event pulse and an optional interrupt pulse.

module timer_unit_ctrl #(
    parameter int PRESC_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_o,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        presc_reset_o,
    output logic        presc_enable_o,
    output logic [31:0] presc_compare_o,
    input  logic        presc_tick_i,
    output logic        cnt_reset_o,
    output logic        cnt_enable_o,
    input  logic        cnt_target_i,
    output logic        event_o,
    output logic        irq_o,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]         state_q, state_d;

    logic               en_q, en_d;
    logic               irqen_q, irqen_d;
    logic               oneshot_q, oneshot_d;
    logic               cmp_clr_q, cmp_clr_d;
    logic               presc_en_q, presc_en_d;
    logic               done_q, done_d;
    logic [PRESC_W-1:0] presc_val_q, presc_val_d;

    logic               rst_pulse_q;
    logic               event_q;
    logic               irq_q;

    logic               cfg_wr_en;
    logic               cfg_wr_dis;
    logic               stop_req;
    logic               arm_req;
    logic               target_hit;
    logic               unused_wdata;

    assign cfg_wr_en  = cfg_we_i & cfg_wdata_i[0];
    assign cfg_wr_dis = cfg_we_i & ~cfg_wdata_i[0];
    assign stop_req   = stop_i | cfg_wr_dis;
    assign arm_req    = (cfg_wr_en | start_i) & ~stop_i;
    assign target_hit = (state_q == ST_RUN) & cnt_target_i;

    assign unused_wdata = ^{cfg_wdata_i[31:8+PRESC_W], cfg_wdata_i[7], cfg_wdata_i[3]};

    // Next-state logic: a stop request outranks a compare hit, which outranks a start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_req) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (stop_req) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_req || (cnt_target_i && oneshot_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next config value: the written fields first, then start/stop/one-shot overrides on EN and DONE.
    always_comb begin
        en_d        = en_q;
        irqen_d     = irqen_q;
        oneshot_d   = oneshot_q;
        cmp_clr_d   = cmp_clr_q;
        presc_en_d  = presc_en_q;
        presc_val_d = presc_val_q;
        done_d      = done_q;

        if (cfg_we_i) begin
            en_d        = cfg_wdata_i[0];
            irqen_d     = cfg_wdata_i[2];
            oneshot_d   = cfg_wdata_i[4];
            cmp_clr_d   = cfg_wdata_i[5];
            presc_en_d  = cfg_wdata_i[6];
            presc_val_d = cfg_wdata_i[8 +: PRESC_W];
        end

        if (start_i && (state_q == ST_IDLE)) begin
            en_d = 1'b1;
        end

        // A stop leaves the channel disabled so EN reads back as not running.
        if (stop_i) begin
            en_d = 1'b0;
        end

        if (target_hit && oneshot_q) begin
            en_d   = 1'b0;
            done_d = 1'b1;
        end

        if ((state_q == ST_IDLE) && (state_d == ST_ARM)) begin
            done_d = 1'b0;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            irqen_q     <= 1'b0;
            oneshot_q   <= 1'b0;
            cmp_clr_q   <= 1'b0;
            presc_en_q  <= 1'b0;
            presc_val_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            irqen_q     <= irqen_d;
            oneshot_q   <= oneshot_d;
            cmp_clr_q   <= cmp_clr_d;
            presc_en_q  <= presc_en_d;
            presc_val_q <= presc_val_d;
            done_q      <= done_d;
        end
    end

    // Self-clearing RST request plus the registered event and interrupt pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_pulse_q <= 1'b0;
            event_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rst_pulse_q <= cfg_we_i & cfg_wdata_i[1];
            event_q     <= target_hit;
            irq_q       <= target_hit & irqen_q;
        end
    end

    // Counter controls follow the state; a pending RST request forces both resets in any state.
    always_comb begin
        presc_reset_o  = 1'b0;
        presc_enable_o = 1'b0;
        cnt_reset_o    = 1'b0;
        cnt_enable_o   = 1'b0;
        case (state_q)
            ST_ARM: begin
                presc_reset_o = 1'b1;
                cnt_reset_o   = 1'b1;
            end
            ST_RUN: begin
                presc_enable_o = presc_en_q;
                cnt_enable_o   = presc_en_q ? presc_tick_i : 1'b1;
                cnt_reset_o    = cnt_target_i & cmp_clr_q;
            end
            default: begin
                presc_enable_o = 1'b0;
            end
        endcase
        presc_reset_o = presc_reset_o | rst_pulse_q;
        cnt_reset_o   = cnt_reset_o | rst_pulse_q;
    end

    // Config readback: RST always reads 0, DONE sits in the top bit.
    always_comb begin
        cfg_o                = '0;
        cfg_o[0]             = en_q;
        cfg_o[2]             = irqen_q;
        cfg_o[4]             = oneshot_q;
        cfg_o[5]             = cmp_clr_q;
        cfg_o[6]             = presc_en_q;
        cfg_o[8 +: PRESC_W]  = presc_val_q;
        cfg_o[31]            = done_q;
    end

    assign presc_compare_o = {{(32-PRESC_W){1'b0}}, presc_val_q};
    assign event_o         = event_q;
    assign irq_o           = irq_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_timer_unit_ctrl.sv
// tb_timer_unit_ctrl: directed bench for timer_unit_ctrl.
// Event/irq pulses are checked by a scoreboard monitor; combinational
// controls and config readback are checked inline.

module tb_timer_unit_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rd;
    logic        start;
    logic        stop;
    logic        presc_reset;
    logic        presc_enable;
    logic [31:0] presc_compare;
    logic        presc_tick;
    logic        cnt_reset;
    logic        cnt_enable;
    logic        cnt_target;
    logic        evt;
    logic        irq;
    logic        busy;

    int total;
    int bad;
    int cycle_cnt;

    typedef struct {
        logic irq;
        int   cyc;
    } exp_t;

    exp_t expq[$];

    timer_unit_ctrl #(.PRESC_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_we_i        (cfg_we),
        .cfg_wdata_i     (cfg_wdata),
        .cfg_o           (cfg_rd),
        .start_i         (start),
        .stop_i          (stop),
        .presc_reset_o   (presc_reset),
        .presc_enable_o  (presc_enable),
        .presc_compare_o (presc_compare),
        .presc_tick_i    (presc_tick),
        .cnt_reset_o     (cnt_reset),
        .cnt_enable_o    (cnt_enable),
        .cnt_target_i    (cnt_target),
        .event_o         (evt),
        .irq_o           (irq),
        .busy_o          (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts active edges so the monitor can check pulse latency.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic we, input logic [31:0] wdata, input logic st,
                                 input logic sp, input logic tick, input logic target);
        @(negedge clk);
        cfg_we     = we;
        cfg_wdata  = wdata;
        start      = st;
        stop       = sp;
        presc_tick = tick;
        cnt_target = target;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Record an expected event pulse one cycle after the current input cycle.
    task automatic pushExpect(input logic exp_irq);
        exp_t e;
        e.irq = exp_irq;
        e.cyc = cycle_cnt + 1;
        expq.push_back(e);
    endtask

    // Scoreboard monitor: every event/irq pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (evt || irq)) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse: got event=%0b irq=%0b expected none (cycle %0d)", evt, irq, cycle_cnt);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("event_pulse", {31'b0, evt}, 32'd1);
                checkOutput("irq_pulse", {31'b0, irq}, {31'b0, e.irq});
                checkOutput("event_cycle", cycle_cnt, e.cyc);
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        cycle_cnt  = 0;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_wdata  = 32'h0;
        start      = 1'b0;
        stop       = 1'b0;
        presc_tick = 1'b0;
        cnt_target = 1'b0;

        // Reset state.
        @(negedge clk);
        #1;
        checkOutput("rst_cfg", cfg_rd, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_cnt_en", {31'b0, cnt_enable}, 32'd0);
        checkOutput("rst_presc_cmp", presc_compare, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // EN + IRQEN + CMP_CLR, no prescaler; target every 5 cycles.
        $display("[TB] free-running compare with clear");
        applyStimulus(1'b1, 32'h0000_0025, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_still_idle", {31'b0, busy}, 32'd0);
        idleCycle();
        checkOutput("arm_busy", {31'b0, busy}, 32'd1);
        checkOutput("arm_presc_rst", {31'b0, presc_reset}, 32'd1);
        checkOutput("arm_cnt_rst", {31'b0, cnt_reset}, 32'd1);
        checkOutput("arm_cnt_en", {31'b0, cnt_enable}, 32'd0);
        checkOutput("arm_cfg", cfg_rd, 32'h0000_0025);
        idleCycle();
        checkOutput("run_cnt_en", {31'b0, cnt_enable}, 32'd1);
        checkOutput("run_cnt_rst", {31'b0, cnt_reset}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                idleCycle();
                checkOutput("run_en_const", {31'b0, cnt_enable}, 32'd1);
            end
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("cmp_clr_rst", {31'b0, cnt_reset}, 32'd1);
            pushExpect(1'b1);
        end

        // Enable prescaler with PRESC_VAL=3 while running.
        $display("[TB] prescaler gating");
        applyStimulus(1'b1, 32'h0000_0365, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("presc_cfg", cfg_rd, 32'h0000_0365);
        checkOutput("presc_cmp", presc_compare, 32'd3);
        checkOutput("presc_en", {31'b0, presc_enable}, 32'd1);
        checkOutput("presc_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            logic t;
            t = ((i % 4) == 3);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, t, 1'b0);
            checkOutput("gated_cnt_en", {31'b0, cnt_enable}, {31'b0, t});
        end

        // One-shot without interrupt.
        $display("[TB] one-shot");
        applyStimulus(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("os_cnt_en", {31'b0, cnt_enable}, 32'd1);
        checkOutput("os_cnt_rst", {31'b0, cnt_reset}, 32'd0);
        pushExpect(1'b0);
        idleCycle();
        checkOutput("os_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("os_done_cfg", cfg_rd, 32'h8000_0010);
        checkOutput("os_idle_en", {31'b0, cnt_enable}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_target_rst", {31'b0, cnt_reset}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_idle", {31'b0, busy}, 32'd0);
        idleCycle();
        checkOutput("restart_arm_busy", {31'b0, busy}, 32'd1);
        checkOutput("restart_arm_rst", {31'b0, cnt_reset}, 32'd1);
        checkOutput("restart_cfg", cfg_rd, 32'h0000_0011);

        // Stop coincident with a compare hit.
        $display("[TB] stop with target");
        applyStimulus(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stop_pre_run", {31'b0, cnt_enable}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stop_cfg", cfg_rd, 32'h0000_0005);
        checkOutput("stop_cnt_rst", {31'b0, cnt_reset}, 32'd0);
        checkOutput("stop_presc_rst", {31'b0, presc_reset}, 32'd0);
        pushExpect(1'b1);
        idleCycle();
        checkOutput("stop_busy", {31'b0, busy}, 32'd0);
        checkOutput("stop_idle_en", {31'b0, cnt_enable}, 32'd0);
        checkOutput("stop_idle_rst", {31'b0, cnt_reset}, 32'd0);
        checkOutput("stop_done", {31'b0, cfg_rd[31]}, 32'd0);

        // RST request while running.
        $display("[TB] RST pulse during run");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstw_run", {31'b0, cnt_enable}, 32'd1);
        idleCycle();
        checkOutput("rstw_presc_rst", {31'b0, presc_reset}, 32'd1);
        checkOutput("rstw_cnt_rst", {31'b0, cnt_reset}, 32'd1);
        checkOutput("rstw_still_run", {31'b0, cnt_enable}, 32'd1);
        checkOutput("rstw_cfg", cfg_rd, 32'h0000_0005);
        idleCycle();
        checkOutput("rstw_clear_p", {31'b0, presc_reset}, 32'd0);
        checkOutput("rstw_clear_c", {31'b0, cnt_reset}, 32'd0);
        checkOutput("rstw_busy", {31'b0, busy}, 32'd1);

        // Asynchronous reset mid-run.
        $display("[TB] reset mid-run");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_cfg", cfg_rd, 32'h0);
        checkOutput("midrst_cnt_en", {31'b0, cnt_enable}, 32'd0);
        checkOutput("midrst_evt", {31'b0, evt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idleCycle();
        idleCycle();
        checkOutput("post_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("scoreboard_empty", expq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
